// File: rtl/piso_shift_transmitter_if.sv
// piso_shift_transmitter_if
//   Load handshake and serial link bundle for the PISO transmitter.
//   slave  : transmitter side (consumes en/load_valid/data_in, drives the rest)
//   master : producer/consumer side (drives en/load_valid/data_in)
//   Signals:
//     en          shift enable
//     load_valid  data_in holds a word to send
//     data_in     parallel word, WIDTH bits
//     load_ready  transmitter captures data_in this cycle if load_valid
//     sout        serial data bit
//     sout_valid  sout is a live bit this cycle
//     frame_done  pulse on the cycle the last bit of a word is sent
//     busy        a word is in flight
interface piso_shift_transmitter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             load_valid;
   logic [WIDTH-1:0] data_in;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             frame_done;
   logic             busy;

   modport slave (
      input  en,
      input  load_valid,
      input  data_in,
      output load_ready,
      output sout,
      output sout_valid,
      output frame_done,
      output busy
   );

   modport master (
      output en,
      output load_valid,
      output data_in,
      input  load_ready,
      input  sout,
      input  sout_valid,
      input  frame_done,
      input  busy
   );
endinterface

// File: rtl/piso_shift_transmitter.sv
// piso_shift_transmitter
//   Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a
//   valid/ready load handshake and sends it one bit per enabled clock, with a
//   valid strobe and an end-of-frame pulse. Back-to-back words stream without
//   a gap cycle: the next word is loaded on the cycle the last bit goes out.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; aborts any word in flight
//     bus  piso_shift_transmitter_if.slave (handshake + serial link)
//   Parameters:
//     WIDTH      word width, >= 2
//     LSB_FIRST  1: bit 0 first (feeds a right-shift receiver); 0: MSB first
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no word held; load_ready high, en ignored
//   SHIFT | word in shreg; one bit sent per en=1 cycle, cnt = bits sent
module piso_shift_transmitter #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   piso_shift_transmitter_if.slave bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;

   logic sending;
   logic last;
   logic ready;
   logic load;

   // Outputs depend only on registered state plus en/load_valid/rst, so
   // data_in never reaches an output combinationally.
   assign sending = (state == SHIFT) & bus.en;
   assign last    = sending & (cnt == CNT_LAST);
   assign ready   = ~rst & ((state == IDLE) | last);
   assign load    = bus.load_valid & ready;

   assign bus.sout       = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
   assign bus.sout_valid = sending;
   assign bus.frame_done = last;
   assign bus.load_ready = ready;
   assign bus.busy       = (state == SHIFT);

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (load) begin
               shreg_nxt = bus.data_in;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               cnt_nxt = '0;
               if (load) begin
                  // next word starts on the very next cycle, no bubble
                  shreg_nxt = bus.data_in;
               end else begin
                  shreg_nxt = '0;
                  state_nxt = IDLE;
               end
            end else if (sending) begin
               if (LSB_FIRST)
                  shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
               else
                  shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// tb_piso_shift_transmitter
//   Directed bench: one LSB-first and one MSB-first transmitter (WIDTH=4)
//   driven with identical stimulus, checked against hand-computed values.
module tb_piso_shift_transmitter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic [3:0] rx;

   piso_shift_transmitter_if #(.WIDTH(4)) bus_l ();
   piso_shift_transmitter_if #(.WIDTH(4)) bus_m ();

   piso_shift_transmitter #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut_l (
      .clk (clk),
      .rst (rst),
      .bus (bus_l.slave)
   );

   piso_shift_transmitter #(.WIDTH(4), .LSB_FIRST(1'b0)) u_dut_m (
      .clk (clk),
      .rst (rst),
      .bus (bus_m.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // right-shift receiver on the LSB-first link
   always @(posedge clk) begin
      if (rst)
         rx <= 4'b0000;
      else if (bus_l.sout_valid)
         rx <= {bus_l.sout, rx[3:1]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drive inputs 1 time unit after the edge, leave time to settle before checks
   task automatic drive(input logic r, input logic e, input logic lv, input logic [3:0] d);
      @(posedge clk);
      #1;
      rst              = r;
      bus_l.en         = e;
      bus_l.load_valid = lv;
      bus_l.data_in    = d;
      bus_m.en         = e;
      bus_m.load_valid = lv;
      bus_m.data_in    = d;
      #3;
   endtask

   task automatic check_l(input string tag, input logic so, input logic sv,
                          input logic fd, input logic bz, input logic lr);
      check({tag, ".sout"},       32'(bus_l.sout),       32'(so));
      check({tag, ".sout_valid"}, 32'(bus_l.sout_valid), 32'(sv));
      check({tag, ".frame_done"}, 32'(bus_l.frame_done), 32'(fd));
      check({tag, ".busy"},       32'(bus_l.busy),       32'(bz));
      check({tag, ".load_ready"}, 32'(bus_l.load_ready), 32'(lr));
   endtask

   int   gap_en   [7] = '{1, 0, 0, 1, 1, 0, 1};
   int   gap_sout [7] = '{0, 1, 1, 1, 1, 0, 0};
   int   lsb_bits [4] = '{1, 1, 0, 1};
   int   msb_bits [4] = '{1, 0, 1, 1};
   int   b2b_bits [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
   int   rst_bits [4] = '{1, 1, 0, 0};

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus_l.en = 1'b0; bus_l.load_valid = 1'b0; bus_l.data_in = 4'h0;
      bus_m.en = 1'b0; bus_m.load_valid = 1'b0; bus_m.data_in = 4'h0;

      // reset then idle
      drive(1'b1, 1'b0, 1'b1, 4'h9);
      drive(1'b1, 1'b1, 1'b1, 4'h9);
      check("rst.load_ready", 32'(bus_l.load_ready), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 4'h0);
      check_l("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("idle0.m_sout", 32'(bus_m.sout), 32'd0);
      drive(1'b0, 1'b1, 1'b0, 4'h0);
      check_l("idle_en1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 4'h0);
      check_l("idle_en0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // single word 4'b1011, both bit orders
      drive(1'b0, 1'b1, 1'b1, 4'b1011);
      check_l("sw.load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0, 4'b0100);   // data_in changes must not matter
         check_l($sformatf("sw.bit%0d", i), 1'(lsb_bits[i]), 1'b1, 1'(i == 3), 1'b1, 1'(i == 3));
         check($sformatf("msb.bit%0d", i), 32'(bus_m.sout), 32'(msb_bits[i]));
         check($sformatf("msb.fd%0d", i), 32'(bus_m.frame_done), 32'(i == 3));
      end
      drive(1'b0, 1'b1, 1'b0, 4'h0);
      check_l("sw.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("sw.rx", 32'(rx), 32'hB);

      // enable gaps, word 4'b0110
      drive(1'b0, 1'b0, 1'b1, 4'b0110);
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'(gap_en[i]), 1'b0, 4'h0);
         check_l($sformatf("gap.c%0d", i), 1'(gap_sout[i]), 1'(gap_en[i]),
                 1'(i == 6), 1'b1, 1'(i == 6));
      end
      drive(1'b0, 1'b0, 1'b0, 4'h0);
      check("gap.busy_after", 32'(bus_l.busy), 32'd0);
      check("gap.rx", 32'(rx), 32'h6);

      // back-to-back 4'hA then 4'h5
      drive(1'b0, 1'b1, 1'b1, 4'hA);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 1'(i < 4), 4'h5);
         check_l($sformatf("b2b.bit%0d", i), 1'(b2b_bits[i]), 1'b1,
                 1'(i == 3 || i == 7), 1'b1, 1'(i == 3 || i == 7));
      end
      drive(1'b0, 1'b1, 1'b0, 4'h0);
      check_l("b2b.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("b2b.rx", 32'(rx), 32'h5);

      // mid-frame reset
      drive(1'b0, 1'b1, 1'b1, 4'hF);
      drive(1'b0, 1'b1, 1'b0, 4'h0);
      check("mfr.bit0", 32'(bus_l.sout), 32'd1);
      drive(1'b0, 1'b1, 1'b0, 4'h0);
      check("mfr.bit1", 32'(bus_l.sout), 32'd1);
      drive(1'b1, 1'b1, 1'b1, 4'h0);
      check("mfr.rst_ready", 32'(bus_l.load_ready), 32'd0);
      check("mfr.rst_fd", 32'(bus_l.frame_done), 32'd0);
      drive(1'b0, 1'b1, 1'b1, 4'h3);
      check_l("mfr.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0, 4'h0);
         check_l($sformatf("mfr.bit%0d", i), 1'(rst_bits[i]), 1'b1, 1'(i == 3), 1'b1, 1'(i == 3));
      end
      drive(1'b0, 1'b0, 1'b0, 4'h0);
      check("mfr.busy_after", 32'(bus_l.busy), 32'd0);
      check("mfr.rx", 32'(rx), 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/piso_shift_transmitter.md
# piso_shift_transmitter

Parallel-in, serial-out shift transmitter: the sending end of the serial bit link consumed by the right-shifting serial-in register. It accepts a WIDTH-bit word over a valid/ready load handshake, then emits it one bit per enabled clock with a qualifying valid strobe and an end-of-frame pulse. With LSB_FIRST=1, a right-shift receiver clocked on `sout_valid` holds the original word after WIDTH valid bits. Back-to-back words stream without a gap cycle.

## Interface
- `WIDTH`, default 4: word width in bits; legal range ≥2.
- `LSB_FIRST`, default 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  shift enable; a bit is transmitted only on cycles with en=1.
- `load_valid`  in  1  `data_in` holds a word to send.
- `data_in`  in  WIDTH  parallel word.
- `load_ready`  out  1  transmitter will capture `data_in` this cycle if `load_valid`=1.
- `sout`  out  1  serial data bit.
- `sout_valid`  out  1  `sout` is a live bit this cycle.
- `frame_done`  out  1  one-cycle pulse on the cycle the last bit of a word is sent.
- `busy`  out  1  a word is in flight (state SHIFT).

## Operation
- State: `state` ∈ {IDLE, SHIFT}; `shreg` WIDTH bits; `cnt` of $clog2(WIDTH) bits.
- Reset (rst=1 at edge): state←IDLE, shreg←0, cnt←0. Reset takes priority over every other input, including mid-frame; an aborted word is dropped, no `frame_done`.
- `sout` = shreg[0] if LSB_FIRST else shreg[WIDTH-1], in every state (0 after reset).
- `sout_valid` = (state==SHIFT) & en.
- `last` = sout_valid & (cnt==WIDTH-1); `frame_done` = last.
- `load_ready` = ~rst & ((state==IDLE) | last).
- `busy` = (state==SHIFT).
- `load` = load_valid & load_ready.
- IDLE: on load → shreg←data_in, cnt←0, state←SHIFT. `en` is ignored in IDLE.
- SHIFT, en=0: all state held; `sout` holds its value; no bit counted.
- SHIFT, en=1, not last: shreg shifts toward the output end (LSB_FIRST: right, zero into MSB; else left, zero into LSB), cnt←cnt+1.
- SHIFT, last: if load → shreg←data_in, cnt←0, stay SHIFT (back-to-back); else shreg←0, cnt←0, state←IDLE.
- `data_in` is sampled only on a load cycle; later changes have no effect on the word in flight.

## Timing
- All outputs are combinational from registered state plus `en`/`load_valid`/`rst`; no combinational path from `data_in` to any output.
- Load-to-first-bit latency: first bit appears on `sout` the cycle after the load edge; it is sent on the first following cycle with en=1.
- A word occupies exactly WIDTH cycles with en=1; en=0 cycles stretch the frame without loss.
- Continuous en=1 and load_valid=1: one word per WIDTH cycles, `sout_valid` never deasserts, `frame_done` every WIDTH cycles.
- After reset: sout=0, sout_valid=0, frame_done=0, busy=0; load_ready=0 while rst=1, 1 on the first cycle rst=0.

## Test plan
- Reset then idle: rst high 2 cycles, drop → sout=0, sout_valid=0, busy=0, frame_done=0, load_ready=1; en toggling in IDLE changes nothing.
- Single word, WIDTH=4, LSB_FIRST=1: load 4'b1011, en=1 → sout 1,1,0,1 on four consecutive valid cycles, frame_done on the 4th only, busy drops and load_ready=1 the following cycle; SIPO receiver on sout/sout_valid ends at 4'b1011.
- MSB-first: LSB_FIRST=0, load 4'b1011 → sout 1,0,1,1; frame_done on the 4th bit.
- Enable gaps: load 4'b0110, en pattern 1,0,0,1,1,0,1 → bits 0,1,1,0 on the en=1 cycles only; sout holds across gaps; frame_done coincident with the last en=1 cycle.
- Back-to-back: load_valid held, words 4'hA then 4'h5 → 8 contiguous valid bits 0,1,0,1,1,0,1,0, load_ready high on bit 4, frame_done on bits 4 and 8, busy never drops.
- Mid-frame reset: load 4'hF, send 2 bits, assert rst → next cycle busy=0, sout_valid=0, no frame_done; new load 4'h3 afterwards sends 1,1,0,0.
